// File: rtl/iir_biquad_mc.sv
// rtl/iir_biquad_mc.sv - multi-channel time-multiplexed Direct Form I biquad IIR filter
//
// Purpose: one shared multiplier datapath filters N_CH interleaved channels.
//   Each channel keeps its own x[n-1], x[n-2], y[n-1], y[n-2] history.
//   A sample is accepted when vin=1 and ch_in < N_CH, and its result is
//   registered at that same edge (1-cycle latency).
//   Coefficients are Q(W-2) signed fixed point (W=9: 128 = 1.0).
//
// Configuration macro: IIR_SAT_EN
//   defined   -> out-of-range results clamp to the W-bit signed limits
//   undefined -> out-of-range results wrap to their W LSBs
//
// Ports:
//   clk      in   1   rising-edge clock
//   rst      in   1   asynchronous active-high reset
//   vin      in   1   input sample valid
//   din      in   W   input sample (signed)
//   ch_in    in   CW  channel tag of din
//   coef_ld  in   1   coefficient load strobe
//   b0..a2   in   W   coefficients (signed, scale 2^(W-2))
//   vout     out  1   output sample valid
//   dout     out  W   filtered sample (signed)
//   ch_out   out  CW  channel tag of dout
//   err      out  1   sticky illegal-channel flag
module iir_biquad_mc #(
  parameter int W    = 9,
  parameter int N_CH = 2,
  parameter int CW   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                vin,
  input  logic signed [W-1:0] din,
  input  logic [CW-1:0]       ch_in,
  input  logic                coef_ld,
  input  logic signed [W-1:0] b0,
  input  logic signed [W-1:0] b1,
  input  logic signed [W-1:0] b2,
  input  logic signed [W-1:0] a1,
  input  logic signed [W-1:0] a2,
  output logic                vout,
  output logic signed [W-1:0] dout,
  output logic [CW-1:0]       ch_out,
  output logic                err
);

  localparam int ACC_W = 2 * W + 3;
  localparam int FRAC  = W - 2;
  // One extra bit so that N_CH = 2^CW is still representable for the compare.
  localparam logic [CW:0] N_CH_V = (CW + 1)'(N_CH);

  // Full-precision signed W x W product, operands sign-extended explicitly.
  function automatic logic signed [2*W-1:0] mul(input logic signed [W-1:0] a,
                                                input logic signed [W-1:0] b);
    return $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
  endfunction

  function automatic logic signed [ACC_W-1:0] ext(input logic signed [2*W-1:0] p);
    return $signed({{(ACC_W - 2*W){p[2*W-1]}}, p});
  endfunction

  logic signed [W-1:0] c_b0, c_b1, c_b2, c_a1, c_a2;

  logic signed [W-1:0] xs1 [N_CH];
  logic signed [W-1:0] xs2 [N_CH];
  logic signed [W-1:0] ys1 [N_CH];
  logic signed [W-1:0] ys2 [N_CH];

  logic                    ch_ok;
  logic                    accept;
  logic [CW-1:0]           ch_idx;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sh;
  logic signed [W-1:0]     y_red;

  assign ch_ok  = ({1'b0, ch_in} < N_CH_V);
  assign accept = vin & ch_ok;
  // Keep the history lookup in range even while an illegal tag is presented.
  assign ch_idx = ch_ok ? ch_in : '0;

  always_comb begin
    acc = ext(mul(c_b0, din))
        + ext(mul(c_b1, xs1[ch_idx]))
        + ext(mul(c_b2, xs2[ch_idx]))
        - ext(mul(c_a1, ys1[ch_idx]))
        - ext(mul(c_a2, ys2[ch_idx]));
    sh = acc >>> FRAC;
`ifdef IIR_SAT_EN
    // Bits above the W-bit result must all equal its sign bit to be in range.
    if (!sh[ACC_W-1] && (|sh[ACC_W-2:W-1])) begin
      y_red = {1'b0, {(W-1){1'b1}}};
    end else if (sh[ACC_W-1] && !(&sh[ACC_W-2:W-1])) begin
      y_red = {1'b1, {(W-1){1'b0}}};
    end else begin
      y_red = sh[W-1:0];
    end
`else
    y_red = W'(sh);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vout   <= 1'b0;
      dout   <= '0;
      ch_out <= '0;
      err    <= 1'b0;
      c_b0   <= '0;
      c_b1   <= '0;
      c_b2   <= '0;
      c_a1   <= '0;
      c_a2   <= '0;
      for (int i = 0; i < N_CH; i++) begin
        xs1[i] <= '0;
        xs2[i] <= '0;
        ys1[i] <= '0;
        ys2[i] <= '0;
      end
    end else begin
      // A sample arriving with coef_ld sees the old coefficients, since the
      // datapath reads the registers, not the coefficient inputs.
      if (coef_ld) begin
        c_b0 <= b0;
        c_b1 <= b1;
        c_b2 <= b2;
        c_a1 <= a1;
        c_a2 <= a2;
      end
      if (accept) begin
        vout        <= 1'b1;
        dout        <= y_red;
        ch_out      <= ch_in;
        xs2[ch_idx] <= xs1[ch_idx];
        xs1[ch_idx] <= din;
        ys2[ch_idx] <= ys1[ch_idx];
        ys1[ch_idx] <= y_red;
      end else begin
        vout <= 1'b0;
      end
      if (vin && !ch_ok) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_iir_biquad_mc.sv
// tb/tb_iir_biquad_mc.sv - directed table-driven bench for iir_biquad_mc
module tb_iir_biquad_mc;

  localparam int W    = 9;
  localparam int N_CH = 3;
  localparam int CW   = 2;

`ifdef IIR_SAT_EN
  localparam int BIG_Y = 255;
`else
  localparam int BIG_Y = -4;
`endif

  logic                clk;
  logic                rst;
  logic                vin;
  logic signed [W-1:0] din;
  logic [CW-1:0]       ch_in;
  logic                coef_ld;
  logic signed [W-1:0] b0, b1, b2, a1, a2;
  logic                vout;
  logic signed [W-1:0] dout;
  logic [CW-1:0]       ch_out;
  logic                err;

  iir_biquad_mc #(.W(W), .N_CH(N_CH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .vin(vin), .din(din), .ch_in(ch_in),
    .coef_ld(coef_ld), .b0(b0), .b1(b1), .b2(b2), .a1(a1), .a2(a2),
    .vout(vout), .dout(dout), .ch_out(ch_out), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int vin; int din; int ch; int ld;
    int b0; int b1; int b2; int a1; int a2;
    int e_vout; int e_dout; int e_ch; int e_err;
  } vec_t;

  vec_t tbl[$];
  int total = 0;
  int bad = 0;

  task automatic add(input int vi, input int d, input int c, input int ld,
                     input int cb0, input int cb1, input int cb2, input int ca1, input int ca2,
                     input int ev, input int ed, input int ec, input int ee);
    vec_t v;
    v.vin = vi; v.din = d; v.ch = c; v.ld = ld;
    v.b0 = cb0; v.b1 = cb1; v.b2 = cb2; v.a1 = ca1; v.a2 = ca2;
    v.e_vout = ev; v.e_dout = ed; v.e_ch = ec; v.e_err = ee;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %0d expected %0d", nm, idx, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int idx,
                            input int ev, input int ed, input int ec, input int ee);
    int d;
    d = dout;
    chk({tag, ".vout"}, idx, int'(vout), ev);
    chk({tag, ".dout"}, idx, d, ed);
    chk({tag, ".ch_out"}, idx, int'(ch_out), ec);
    chk({tag, ".err"}, idx, int'(err), ee);
  endtask

  task automatic apply(input vec_t v);
    vin     = v.vin[0];
    din     = v.din[W-1:0];
    ch_in   = v.ch[CW-1:0];
    coef_ld = v.ld[0];
    b0 = v.b0[W-1:0];
    b1 = v.b1[W-1:0];
    b2 = v.b2[W-1:0];
    a1 = v.a1[W-1:0];
    a2 = v.a2[W-1:0];
  endtask

  task automatic step(input string tag, input int idx, input vec_t v);
    apply(v);
    @(posedge clk);
    #1;
    check_outs(tag, idx, v.e_vout, v.e_dout, v.e_ch, v.e_err);
  endtask

  initial begin
    vec_t v;
    //  vin din  ch ld  b0  b1 b2  a1   a2  | vout dout ch err
    add(1,  50,  1, 0,   0,  0, 0,   0,   0,  1,   0,   1, 0); // coefs are 0 after reset
    add(1,   0,  0, 1, 128,  0, 0, -64,   0,  1,   0,   0, 0); // load + sample: old coefs
    add(1, 100,  0, 0,   0,  0, 0,   0,   0,  1, 100,   0, 0); // impulse decay
    add(1,   0,  0, 0,   0,  0, 0,   0,   0,  1,  50,   0, 0);
    add(1,   0,  0, 0,   0,  0, 0,   0,   0,  1,  25,   0, 0);
    add(1,   0,  0, 0,   0,  0, 0,   0,   0,  1,  12,   0, 0);
    add(1,   0,  0, 0,   0,  0, 0,   0,   0,  1,   6,   0, 0);
    add(1,   0,  0, 0,   0,  0, 0,   0,   0,  1,   3,   0, 0);
    add(1,   0,  0, 0,   0,  0, 0,   0,   0,  1,   1,   0, 0);
    add(1,   0,  0, 0,   0,  0, 0,   0,   0,  1,   0,   0, 0);
    add(0,  77,  0, 0,   0,  0, 0,   0,   0,  0,   0,   0, 0); // idle: hold
    add(1, 100,  0, 0,   0,  0, 0,   0,   0,  1, 100,   0, 0); // interleaved ch0/ch1
    add(1,   0,  1, 0,   0,  0, 0,   0,   0,  1,   0,   1, 0);
    add(1,   0,  0, 0,   0,  0, 0,   0,   0,  1,  50,   0, 0);
    add(1,   0,  1, 0,   0,  0, 0,   0,   0,  1,   0,   1, 0);
    add(1,   0,  0, 0,   0,  0, 0,   0,   0,  1,  25,   0, 0);
    add(1,   0,  1, 0,   0,  0, 0,   0,   0,  1,   0,   1, 0);
    add(0,   0,  0, 1, 128,  0, 0,   0,   0,  0,   0,   1, 0); // pure gain 1.0
    add(1, 100,  0, 0,   0,  0, 0,   0,   0,  1, 100,   0, 0);
    add(1, -37,  1, 0,   0,  0, 0,   0,   0,  1, -37,   1, 0);
    add(1, 100,  3, 0,   0,  0, 0,   0,   0,  0, -37,   1, 1); // illegal channel
    add(1,  20,  2, 0,   0,  0, 0,   0,   0,  1,  20,   2, 1); // last legal channel
    add(0,   0,  0, 1, 255,  0, 0,   0,   0,  0,  20,   2, 1);
    add(1, 255,  2, 0,   0,  0, 0,   0,   0,  1, BIG_Y, 2, 1); // overflow
    add(0,   0,  0, 1,   0,  0, 0, -128,  0,  0, BIG_Y, 2, 1); // y = y[n-1]
    add(1,   0,  2, 0,   0,  0, 0,   0,   0,  1, BIG_Y, 2, 1);
    add(0,   0,  0, 1,  64,  0, 0,   0,   0,  0, BIG_Y, 2, 1);
    add(1,  -3,  1, 0,   0,  0, 0,   0,   0,  1,  -2,   1, 1); // floor of -1.5
    add(0,   0,  0, 1,   0, 128, 64, 0, -128, 0,  -2,   1, 1);
    add(1,   9,  1, 0,   0,  0, 0,   0,   0,  1, -59,   1, 1); // b1,b2,a2 taps

    rst = 1'b1; vin = 1'b0; din = '0; ch_in = '0; coef_ld = 1'b0;
    b0 = '0; b1 = '0; b2 = '0; a1 = '0; a2 = '0;
    #12;
    check_outs("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) begin
      step("vec", i, tbl[i]);
    end

    // Async reset mid-stream with a sample pending on the inputs.
    v = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    apply(v);
    #2;
    rst = 1'b1;
    #1;
    check_outs("rst_async", 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check_outs("rst_inflight", 0, 0, 0, 0, 0);
    #2;
    rst = 1'b0;
    v = '{1, 100, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    step("post_rst", 0, v);
    v = '{0, 0, 0, 1, 128, 0, 0, -64, 0, 0, 0, 0, 0};
    step("post_rst", 1, v);
    v = '{1, 100, 0, 0, 0, 0, 0, 0, 0, 1, 100, 0, 0};
    step("post_rst", 2, v);
    v = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 50, 0, 0};
    step("post_rst", 3, v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
